// File: rtl/pc_gen_ras_if.sv
// Fetch PC generator bus: redirect sources from D/E in, fetch PC and RAS status out.
// master drives the redirect inputs; slave is the PC generator.
interface pc_gen_ras_if;
    logic        stall_f;
    logic        stall_d;
    logic        valid_d;
    logic        trap_e;
    logic [31:0] pc_trap_e;
    logic        mispred_e;
    logic        actual_take_e;
    logic [31:0] pc_branch_e;
    logic [31:0] pc_plus8_e;
    logic        jump_d;
    logic [31:0] pc_jump_d;
    logic        ret_d;
    logic        call_d;
    logic [31:0] pc_d;
    logic        pred_take_d;
    logic [31:0] pc_branch_d;
    logic [31:0] pc_f;
    logic [1:0]  fetch_cnt_f;
    logic        ras_empty;
    logic [31:0] ras_top;

    modport master (
        output stall_f, stall_d, valid_d, trap_e, pc_trap_e, mispred_e, actual_take_e,
               pc_branch_e, pc_plus8_e, jump_d, pc_jump_d, ret_d, call_d, pc_d,
               pred_take_d, pc_branch_d,
        input  pc_f, fetch_cnt_f, ras_empty, ras_top
    );

    modport slave (
        input  stall_f, stall_d, valid_d, trap_e, pc_trap_e, mispred_e, actual_take_e,
               pc_branch_e, pc_plus8_e, jump_d, pc_jump_d, ret_d, call_d, pc_d,
               pred_take_d, pc_branch_d,
        output pc_f, fetch_cnt_f, ras_empty, ras_top
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator with aligned 1/2-wide fetch, pending E-redirect latch and
// optional return-address stack (enabled by defining RAS_PREDICT_EN).
module pc_gen_ras #(
    parameter logic [31:0] RESET_PC  = 32'hbfc0_0000,
    parameter int          FETCH_W   = 1,
    parameter int          RAS_DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetn,
    pc_gen_ras_if.slave  bus
);
    logic [31:0] pc_q;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic [31:0] ret_tgt;
    logic [31:0] e_tgt;
    logic        e_redirect;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        ras_empty;
    logic [31:0] ras_top;
    logic        unused_pc;

    // A 2-wide group is 8-byte aligned; an odd-word start only has one slot left.
    if (FETCH_W == 2) begin : g_seq2
        assign seq_pc = {pc_q[31:3], 3'b000} + 32'd8;
    end else begin : g_seq1
        assign seq_pc = pc_q + 32'd4;
    end

    assign unused_pc       = ^pc_q[1:0];
    assign bus.pc_f        = pc_q;
    assign bus.fetch_cnt_f = (FETCH_W == 2 && !pc_q[2]) ? 2'd2 : 2'd1;
    assign bus.ras_empty   = ras_empty;
    assign bus.ras_top     = ras_top;

    assign e_redirect = bus.trap_e | bus.mispred_e;
    assign e_tgt      = bus.trap_e        ? bus.pc_trap_e   :
                        bus.actual_take_e ? bus.pc_branch_e : bus.pc_plus8_e;
    assign ret_tgt    = ras_empty ? bus.pc_jump_d : ras_top;

    always_comb begin
        next_pc = seq_pc;
        if (e_redirect)                        next_pc = e_tgt;
        else if (pend_valid)                   next_pc = pend_pc;
        else if (bus.valid_d && bus.ret_d)     next_pc = ret_tgt;
        else if (bus.valid_d && bus.jump_d)    next_pc = bus.pc_jump_d;
        else if (bus.valid_d && bus.pred_take_d) next_pc = bus.pc_branch_d;
    end

    // While fetch is held, the newest E redirect is parked; trap wins via e_tgt.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
        end else if (!bus.stall_f) begin
            pc_q       <= next_pc;
            pend_valid <= 1'b0;
        end else if (e_redirect) begin
            pend_valid <= 1'b1;
            pend_pc    <= e_tgt;
        end
    end

`ifdef RAS_PREDICT_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_ptr;
    logic [CW-1:0] ras_cnt;
    logic          ras_upd;
    logic [31:0]   link_pc;

    assign ras_upd   = bus.valid_d & ~bus.stall_d & ~bus.trap_e & ~bus.mispred_e;
    assign link_pc   = bus.pc_d + 32'd8;
    assign ras_empty = (ras_cnt == '0);
    assign ras_top   = ras_empty ? 32'd0 : ras_mem[ras_ptr];

    // Circular stack: a push when full silently overwrites the oldest entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= 32'd0;
        end else if (bus.trap_e) begin
            ras_cnt <= '0;
        end else if (ras_upd) begin
            if (bus.call_d && bus.ret_d) begin
                ras_mem[ras_ptr] <= link_pc;
                if (ras_cnt == '0) ras_cnt <= CW'(1);
            end else if (bus.call_d) begin
                ras_mem[ras_ptr + PW'(1)] <= link_pc;
                ras_ptr <= ras_ptr + PW'(1);
                if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
            end else if (bus.ret_d && ras_cnt != '0) begin
                ras_ptr <= ras_ptr - PW'(1);
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end
`else
    logic unused_ras;

    assign ras_empty  = 1'b1;
    assign ras_top    = 32'd0;
    assign unused_ras = ^{bus.call_d, bus.stall_d, bus.pc_d};
`endif
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: two instances (FETCH_W=2/RAS_DEPTH=2 and FETCH_W=1/RAS_DEPTH=8)
// share stimulus and are compared against a stack-based reference model.
module tb_pc_gen_ras;
    localparam logic [31:0] RST = 32'hbfc0_0000;
`ifdef RAS_PREDICT_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        stall_f, stall_d, valid_d, trap_e, mispred_e, actual_take_e;
    logic        jump_d, ret_d, call_d, pred_take_d;
    logic [31:0] pc_trap_e, pc_branch_e, pc_plus8_e, pc_jump_d, pc_d, pc_branch_d;

    logic [31:0] obs_pc    [2];
    logic [1:0]  obs_cnt   [2];
    logic        obs_empty [2];
    logic [31:0] obs_top   [2];

    int checks = 0;
    int failures = 0;

    pc_gen_ras_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].stall_f = stall_f;         assign bus[g].stall_d = stall_d;
        assign bus[g].valid_d = valid_d;         assign bus[g].trap_e = trap_e;
        assign bus[g].pc_trap_e = pc_trap_e;     assign bus[g].mispred_e = mispred_e;
        assign bus[g].actual_take_e = actual_take_e;
        assign bus[g].pc_branch_e = pc_branch_e; assign bus[g].pc_plus8_e = pc_plus8_e;
        assign bus[g].jump_d = jump_d;           assign bus[g].pc_jump_d = pc_jump_d;
        assign bus[g].ret_d = ret_d;             assign bus[g].call_d = call_d;
        assign bus[g].pc_d = pc_d;               assign bus[g].pred_take_d = pred_take_d;
        assign bus[g].pc_branch_d = pc_branch_d;
        assign obs_pc[g] = bus[g].pc_f;          assign obs_cnt[g] = bus[g].fetch_cnt_f;
        assign obs_empty[g] = bus[g].ras_empty;  assign obs_top[g] = bus[g].ras_top;

        pc_gen_ras #(.RESET_PC(RST), .FETCH_W(g == 0 ? 2 : 1), .RAS_DEPTH(g == 0 ? 2 : 8))
            u_dut (.clk(clk), .resetn(resetn), .bus(bus[g]));
    end

    // Reference model: plain stack of return addresses, bottom at index 0.
    int          fw  [2] = '{2, 1};
    int          dep [2] = '{2, 8};
    logic [31:0] m_pc  [2];
    logic [31:0] m_pp  [2];
    bit          m_pv  [2];
    logic [31:0] m_stk [2][16];
    int          m_n   [2];

    function automatic logic [1:0] exp_cnt(int k);
        return (fw[k] == 2 && m_pc[k][2]) ? 2'd1 : 2'(fw[k]);
    endfunction
    function automatic logic exp_empty(int k);
        return RAS_EN ? (m_n[k] == 0) : 1'b1;
    endfunction
    function automatic logic [31:0] exp_top(int k);
        return (RAS_EN && m_n[k] > 0) ? m_stk[k][m_n[k]-1] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RST; m_pv[k] = 1'b0; m_pp[k] = 32'd0; m_n[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] nxt, etgt, link;
            etgt = trap_e ? pc_trap_e : (actual_take_e ? pc_branch_e : pc_plus8_e);
            if (fw[k] == 2) nxt = (m_pc[k] & ~32'd7) + 32'd8;
            else            nxt = m_pc[k] + 32'd4;
            if (trap_e || mispred_e)         nxt = etgt;
            else if (m_pv[k])                nxt = m_pp[k];
            else if (valid_d && ret_d)       nxt = (RAS_EN && m_n[k] > 0) ? m_stk[k][m_n[k]-1] : pc_jump_d;
            else if (valid_d && jump_d)      nxt = pc_jump_d;
            else if (valid_d && pred_take_d) nxt = pc_branch_d;
            if (!stall_f) begin
                m_pc[k] = nxt; m_pv[k] = 1'b0;
            end else if (trap_e || mispred_e) begin
                m_pv[k] = 1'b1; m_pp[k] = etgt;
            end
            link = pc_d + 32'd8;
            if (RAS_EN && trap_e) m_n[k] = 0;
            else if (RAS_EN && valid_d && !stall_d && !mispred_e) begin
                if (call_d && ret_d) begin
                    if (m_n[k] == 0) m_n[k] = 1;
                    m_stk[k][m_n[k]-1] = link;
                end else if (call_d) begin
                    if (m_n[k] == dep[k]) begin
                        for (int i = 0; i < dep[k] - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                        m_stk[k][dep[k]-1] = link;
                    end else begin
                        m_stk[k][m_n[k]] = link; m_n[k]++;
                    end
                end else if (ret_d && m_n[k] > 0) m_n[k]--;
            end
        end
    endtask

    task automatic clear_inputs();
        stall_f = 0; stall_d = 0; valid_d = 0; trap_e = 0; mispred_e = 0; actual_take_e = 0;
        jump_d = 0; ret_d = 0; call_d = 0; pred_take_d = 0;
        pc_trap_e = 0; pc_branch_e = 0; pc_plus8_e = 0; pc_jump_d = 0; pc_d = 0; pc_branch_d = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== RST) begin failures++; $display("FAIL reset_pc k=%0d got=%h exp=%h", k, obs_pc[k], RST); end
            checks++; if (obs_cnt[k] !== 2'(fw[k])) begin failures++; $display("FAIL reset_cnt k=%0d got=%0d exp=%0d", k, obs_cnt[k], fw[k]); end
            checks++; if (obs_empty[k] !== 1'b1 || obs_top[k] !== 32'd0) begin failures++; $display("FAIL reset_ras k=%0d empty=%b top=%h exp=1/0", k, obs_empty[k], obs_top[k]); end
        end
        resetn = 1'b1;
        step();
        checks++; if (obs_pc[0] !== 32'hbfc00008) begin failures++; $display("FAIL seq_pc1 got=%h exp=bfc00008", obs_pc[0]); end
        checks++; if (obs_pc[1] !== 32'hbfc00004) begin failures++; $display("FAIL seq_pc1_w1 got=%h exp=bfc00004", obs_pc[1]); end
        step();
        checks++; if (obs_pc[0] !== 32'hbfc00010 || obs_cnt[0] !== 2'd2) begin failures++; $display("FAIL seq_pc2 got=%h/%0d exp=bfc00010/2", obs_pc[0], obs_cnt[0]); end
    endtask

    task automatic test_mispred();
        clear_inputs();
        mispred_e = 1; actual_take_e = 1; pc_branch_e = 32'hbfc00104;
        step();
        checks++; if (obs_pc[0] !== 32'hbfc00104 || obs_cnt[0] !== 2'd1) begin failures++; $display("FAIL mispred_tgt got=%h/%0d exp=bfc00104/1", obs_pc[0], obs_cnt[0]); end
        clear_inputs();
        step();
        checks++; if (obs_pc[0] !== 32'hbfc00108 || obs_cnt[0] !== 2'd2) begin failures++; $display("FAIL unaligned_adv got=%h/%0d exp=bfc00108/2", obs_pc[0], obs_cnt[0]); end
        checks++; if (obs_pc[1] !== 32'hbfc00108 || obs_cnt[1] !== 2'd1) begin failures++; $display("FAIL w1_adv got=%h/%0d exp=bfc00108/1", obs_pc[1], obs_cnt[1]); end
    endtask

    task automatic test_pending();
        clear_inputs();
        stall_f = 1; mispred_e = 1; actual_take_e = 0; pc_plus8_e = 32'h80001010;
        step();
        mispred_e = 0; pc_plus8_e = 0;
        step();
        step();
        checks++; if (obs_pc[0] !== 32'hbfc00108) begin failures++; $display("FAIL stall_hold got=%h exp=bfc00108", obs_pc[0]); end
        stall_f = 0; valid_d = 1; jump_d = 1; pc_jump_d = 32'h80002000;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== 32'h80001010) begin failures++; $display("FAIL pend_beats_jump k=%0d got=%h exp=80001010", k, obs_pc[k]); end
        end
        clear_inputs();
        step();
        checks++; if (obs_pc[0] !== 32'h80001018) begin failures++; $display("FAIL pend_cleared got=%h exp=80001018", obs_pc[0]); end
        checks++; if (obs_pc[1] !== m_pc[1]) begin failures++; $display("FAIL pend_cleared_w1 got=%h exp=%h", obs_pc[1], m_pc[1]); end
    endtask

    task automatic test_trap_pending();
        clear_inputs();
        stall_f = 1; mispred_e = 1; pc_plus8_e = 32'h80001010;
        step();
        mispred_e = 0; trap_e = 1; pc_trap_e = 32'hbfc00380;
        step();
        trap_e = 0;
        step();
        stall_f = 0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== 32'hbfc00380) begin failures++; $display("FAIL trap_over_pend k=%0d got=%h exp=bfc00380", k, obs_pc[k]); end
            checks++; if (obs_empty[k] !== 1'b1) begin failures++; $display("FAIL trap_ras_empty k=%0d got=%b exp=1", k, obs_empty[k]); end
        end
    endtask

    task automatic test_ras();
        logic [31:0] exp0;
        clear_inputs();
        valid_d = 1; call_d = 1;
        pc_d = 32'h100; step();
        pc_d = 32'h200; step();
        pc_d = 32'h300; step();
        exp0 = RAS_EN ? 32'h308 : 32'h0;
        checks++; if (obs_top[0] !== exp0) begin failures++; $display("FAIL ras_top_full got=%h exp=%h", obs_top[0], exp0); end
        call_d = 0; ret_d = 1; pc_jump_d = 32'hdead0000; pc_d = 32'h0;
        step();
        exp0 = RAS_EN ? 32'h308 : 32'hdead0000;
        checks++; if (obs_pc[0] !== exp0) begin failures++; $display("FAIL ret1 got=%h exp=%h", obs_pc[0], exp0); end
        step();
        exp0 = RAS_EN ? 32'h208 : 32'hdead0000;
        checks++; if (obs_pc[0] !== exp0) begin failures++; $display("FAIL ret2 got=%h exp=%h", obs_pc[0], exp0); end
        checks++; if (obs_empty[0] !== 1'b1) begin failures++; $display("FAIL ras_empty_after2 got=%b exp=1", obs_empty[0]); end
        checks++; if (obs_empty[1] !== exp_empty(1) || obs_top[1] !== exp_top(1)) begin failures++; $display("FAIL deep_ras got=%b/%h exp=%b/%h", obs_empty[1], obs_top[1], exp_empty(1), exp_top(1)); end
        step();
        checks++; if (obs_pc[0] !== 32'hdead0000) begin failures++; $display("FAIL ret_underflow got=%h exp=dead0000", obs_pc[0]); end
        checks++; if (obs_pc[1] !== m_pc[1]) begin failures++; $display("FAIL ret3_deep got=%h exp=%h", obs_pc[1], m_pc[1]); end
    endtask

    task automatic test_push_pop();
        logic [31:0] exp0;
        clear_inputs();
        valid_d = 1; call_d = 1; pc_d = 32'h100;
        step();
        ret_d = 1; pc_d = 32'h400; pc_jump_d = 32'h5000;
        step();
        exp0 = RAS_EN ? 32'h108 : 32'h5000;
        checks++; if (obs_pc[0] !== exp0) begin failures++; $display("FAIL pushpop_pc got=%h exp=%h", obs_pc[0], exp0); end
        exp0 = RAS_EN ? 32'h408 : 32'h0;
        checks++; if (obs_top[0] !== exp0) begin failures++; $display("FAIL pushpop_top got=%h exp=%h", obs_top[0], exp0); end
        checks++; if (obs_top[1] !== exp_top(1) || obs_pc[1] !== m_pc[1]) begin failures++; $display("FAIL pushpop_deep got=%h/%h exp=%h/%h", obs_top[1], obs_pc[1], exp_top(1), m_pc[1]); end
        trap_e = 1; pc_trap_e = 32'hbfc00380;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== 32'hbfc00380 || obs_empty[k] !== 1'b1 || obs_top[k] !== 32'd0) begin failures++; $display("FAIL pushpop_trap k=%0d got=%h/%b/%h exp=bfc00380/1/0", k, obs_pc[k], obs_empty[k], obs_top[k]); end
        end
    endtask

    task automatic randomize_inputs();
        stall_f = ($urandom_range(0, 9) < 3);
        stall_d = ($urandom_range(0, 9) < 2);
        valid_d = ($urandom_range(0, 9) < 8);
        trap_e = ($urandom_range(0, 19) == 0);
        mispred_e = ($urandom_range(0, 9) == 0);
        actual_take_e = $urandom_range(0, 1) == 1;
        jump_d = ($urandom_range(0, 3) == 0);
        ret_d = ($urandom_range(0, 3) == 0);
        call_d = ($urandom_range(0, 2) == 0);
        pred_take_d = ($urandom_range(0, 3) == 0);
        pc_trap_e = $urandom & 32'hffff_fffc;  pc_branch_e = $urandom & 32'hffff_fffc;
        pc_plus8_e = $urandom & 32'hffff_fffc; pc_jump_d = $urandom & 32'hffff_fffc;
        pc_d = $urandom & 32'hffff_fffc;       pc_branch_d = $urandom & 32'hffff_fffc;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            step();
            for (int k = 0; k < 2; k++) begin
                checks++; if (obs_pc[k] !== m_pc[k]) begin failures++; $display("FAIL rand_pc n=%0d k=%0d got=%h exp=%h", n, k, obs_pc[k], m_pc[k]); end
                checks++; if (obs_cnt[k] !== exp_cnt(k)) begin failures++; $display("FAIL rand_cnt n=%0d k=%0d got=%0d exp=%0d", n, k, obs_cnt[k], exp_cnt(k)); end
                checks++; if (obs_empty[k] !== exp_empty(k)) begin failures++; $display("FAIL rand_empty n=%0d k=%0d got=%b exp=%b", n, k, obs_empty[k], exp_empty(k)); end
                checks++; if (obs_top[k] !== exp_top(k)) begin failures++; $display("FAIL rand_top n=%0d k=%0d got=%h exp=%h", n, k, obs_top[k], exp_top(k)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        valid_d = 1; call_d = 1; pc_d = 32'h700;
        step();
        call_d = 0; valid_d = 0; stall_f = 1; trap_e = 1; pc_trap_e = 32'h8000_0180;
        step();
        clear_inputs();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== RST || obs_empty[k] !== 1'b1 || obs_top[k] !== 32'd0) begin failures++; $display("FAIL async_reset k=%0d got=%h/%b/%h exp=%h/1/0", k, obs_pc[k], obs_empty[k], obs_top[k], RST); end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (obs_pc[k] !== m_pc[k]) begin failures++; $display("FAIL pend_discarded k=%0d got=%h exp=%h", k, obs_pc[k], m_pc[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_mispred();
        test_pending();
        test_trap_pending();
        test_ras();
        test_push_pop();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Fetch-stage PC generator, successor to the single-issue next-PC register.
- Adds a parametrised reset vector, 1- or 2-wide aligned fetch, a return-address stack (RAS) for `jr $31` prediction, and a pending-redirect latch.
- The latch keeps E-stage redirects (trap, mispredict) from being lost while fetch is stalled.
- Sits between the IF request logic and the D/E redirect sources.

Parameters:
RESET_PC, 32'hbfc0_0000, PC value loaded on reset
FETCH_W, 1, instructions per fetch group (1 or 2); group is 4*FETCH_W bytes, aligned
RAS_DEPTH, 8, return-address stack entries (power of two, 2..16)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
stall_f  in  1  hold pc_f
stall_d  in  1  D stage held; suppresses RAS update
valid_d  in  1  D-stage instruction is valid
trap_e  in  1  exception/eret redirect from E
pc_trap_e  in  32  trap target
mispred_e  in  1  branch in E mispredicted
actual_take_e  in  1  actual direction of E branch
pc_branch_e  in  32  taken target of E branch
pc_plus8_e  in  32  fall-through of E branch
jump_d  in  1  D-stage unconditional jump, not a return
pc_jump_d  in  32  jump target (imm or rs)
ret_d  in  1  D-stage `jr $31`
call_d  in  1  D-stage jal/jalr/bal/bgezal/bltzal (link)
pc_d  in  32  PC of D instruction
pred_take_d  in  1  D-stage branch predicted taken
pc_branch_d  in  32  predicted branch target
pc_f  out  32  current fetch PC
fetch_cnt_f  out  2  valid instructions in group at pc_f (1..FETCH_W)
ras_empty  out  1  RAS holds no entries
ras_top  out  32  current RAS top (0 when empty)

Behaviour:
- Reset (resetn=0, async):
  - pc_f=RESET_PC; fetch_cnt_f=FETCH_W (1 if RESET_PC[2]=1 and FETCH_W=2).
  - RAS count=0, pointer=0, ras_empty=1, ras_top=0.
  - pend_valid=0, pend_pc=0.
- Sequential PC:
  - FETCH_W=1: seq = pc_f+4.
  - FETCH_W=2: seq = {pc_f[31:3],3'b0}+8, so an unaligned group (pc_f[2]=1) advances by 4.
  - fetch_cnt_f = FETCH_W - (FETCH_W==2 & pc_f[2]). Combinational from pc_f.
- Return target: ret_tgt = ras_empty ? pc_jump_d : ras_top.
- Next-PC priority (high to low):
  1. trap_e -> pc_trap_e
  2. mispred_e -> actual_take_e ? pc_branch_e : pc_plus8_e
  3. pend_valid -> pend_pc
  4. valid_d & ret_d -> ret_tgt
  5. valid_d & jump_d -> pc_jump_d
  6. valid_d & pred_take_d -> pc_branch_d
  7. otherwise seq
- Update, stall_f=0:
  - pc_f <= next; pend_valid <= 0.
- Update, stall_f=1:
  - pc_f holds.
  - If trap_e or mispred_e: pend_pc <= its target and pend_valid <= 1.
  - A newer E redirect overwrites an older pending one; trap wins a same-cycle tie.
  - D-stage redirects are not latched; they re-present while D is held.
- RAS update: only when valid_d & ~stall_d & ~trap_e & ~mispred_e.
  - push (call_d): entry[ptr+1] <= pc_d+8; ptr++; count = min(count+1, RAS_DEPTH).
  - Full push overwrites the oldest entry (circular).
  - pop (ret_d): if count>0 then ptr--, count--. Pop when empty has no effect; the target falls back to pc_jump_d.
  - push & pop same cycle: top entry replaced by pc_d+8; ptr and count unchanged (count becomes 1 if it was 0).
- trap_e:
  - Clears the RAS (count=0) on the same edge, regardless of stall_f.
  - mispred_e does not clear the RAS.
- ras_top = entry[ptr] when count>0, else 0. Registered state, combinational read.
- Reset mid-operation: all state returns to reset values immediately; the pending redirect is discarded.

Optional Feature:
- Macro RAS_PREDICT_EN.
- Defined: RAS as above.
- Undefined:
  - No RAS storage is built; ret_d is treated as jump_d (target pc_jump_d).
  - ras_empty tied 1; ras_top tied 0; call_d ignored.
  - All other behaviour is unchanged.

Test Plan:
1. Reset with RESET_PC=32'hbfc0_0000, FETCH_W=2; release resetn, no stalls -> pc_f sequence bfc00000, bfc00008, bfc00010; fetch_cnt_f=2.
2. FETCH_W=2, mispred_e=1, actual_take_e=1, pc_branch_e=32'hbfc00104 -> pc_f=bfc00104, fetch_cnt_f=1; next cycle pc_f=bfc00108, fetch_cnt_f=2.
3. stall_f=1 for 3 cycles, mispred_e=1 with actual_take_e=0, pc_plus8_e=32'h80001010 in cycle 1; jump_d=1 with pc_jump_d=32'h80002000 in cycle 4 when stall_f drops -> pc_f=80001010 (pending beats jump_d); pend_valid cleared.
4. Pending 32'h80001010 latched, then trap_e=1 with pc_trap_e=32'hbfc00380 while still stalled -> after release pc_f=bfc00380; RAS empty.
5. RAS_DEPTH=2: calls at pc_d=100, 200, 300 (no stalls), then three ret_d with pc_jump_d=32'hdead0000 -> targets 308, 208, then dead0000 (oldest overwritten, underflow fallback); ras_empty=1 after the second pop.
6. call_d & ret_d same cycle, pc_d=32'h400 with RAS top 108 -> pc_f=108, ras_top becomes 408, count unchanged; repeat the same cycle with trap_e=1 -> RAS cleared, pc_f=pc_trap_e.
